ym2602_vram_arb: RTL and testbench

- Time-slot arbiter and sequencer for the VDP's single 8-bit VRAM port, which both the CPU data port and the background/sprite fetch engine use.
- Each slot strobe from the display timing starts at most one VRAM access. Render slots always go to the fetch engine. Free slots go to a pending CPU write, else a pending CPU read.
- Generates the active-low CE/OE/WE0/WE1 strobes, the 13-bit word address and the output-data enable, and returns read data to the winner.

---
 rtl/ym2602_vram_pkg.sv | 10 +
 rtl/ym2602_vram_strobe_gen.sv | 99 +++++++++
 rtl/ym2602_vram_arb.sv | 147 ++++++++++++++
 tb/tb_ym2602_vram_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ym2602_vram_pkg.sv
// Shared types for the VDP VRAM arbiter: FSM states, access kinds and default strobe length.
package ym2602_vram_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  typedef enum logic [1:0] {ACC_NONE, ACC_REN, ACC_CPU_RD, ACC_CPU_WR} acc_e;

  localparam int unsigned STROBE_LEN_DEF = 2;

endpackage

// File: rtl/ym2602_vram_strobe_gen.sv
// Access sequencer: IDLE -> SETUP -> STROBE x STROBE_LEN -> HOLD, producing the active-low
// VRAM strobes, bus drive enable, the read-capture pulse and the completion pulse.
module ym2602_vram_strobe_gen
  import ym2602_vram_pkg::*;
#(
  parameter int unsigned STROBE_LEN = STROBE_LEN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_acc,
  input  logic       i_odd,
  output logic       o_idle,
  output logic [1:0] o_acc,
  output logic       o_ce,
  output logic       o_oe,
  output logic       o_we0,
  output logic       o_we1,
  output logic       o_doe,
  output logic       o_capture,
  output logic       o_done
);

  localparam logic [2:0] LAST_CNT = 3'(STROBE_LEN - 1);

  state_e     r_state, w_state_nxt;
  acc_e       r_acc;
  logic       r_odd;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       w_is_wr;

  assign w_is_wr = (r_acc == ACC_CPU_WR);
  assign o_idle  = (r_state == IDLE);
  assign o_acc   = r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= ACC_NONE;
      r_odd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_start && (r_state == IDLE)) begin
        r_acc <= acc_e'(i_acc);
        r_odd <= i_odd;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_ce        = 1'b1;
    o_oe        = 1'b1;
    o_we0       = 1'b1;
    o_we1       = 1'b1;
    o_doe       = 1'b0;
    o_capture   = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && (acc_e'(i_acc) != ACC_NONE)) w_state_nxt = SETUP;
      end
      SETUP: begin
        o_ce        = 1'b0;
        o_doe       = w_is_wr;
        w_cnt_nxt   = '0;
        w_state_nxt = STROBE;
      end
      STROBE: begin
        o_ce  = 1'b0;
        o_doe = w_is_wr;
        if (w_is_wr) begin
          o_we0 = r_odd;
          o_we1 = !r_odd;
        end else begin
          o_oe = 1'b0;
        end
        // VRAM_DI is sampled on the edge that ends the final strobe cycle.
        if (r_cnt == LAST_CNT) begin
          o_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      HOLD: begin
        o_ce        = 1'b0;
        o_doe       = w_is_wr;
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/ym2602_vram_arb.sv
// VDP VRAM slot arbiter: render slots go to the fetch engine, free slots to a pending CPU
// write then read. Define YM2602_VRAM_ARB_STATS_EN to add the STAT_CPU/STAT_WAIT counters.
module ym2602_vram_arb
  import ym2602_vram_pkg::*;
#(
  parameter int unsigned STROBE_LEN = STROBE_LEN_DEF,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic              MCLK,
  input  logic              RESET,
`ifdef YM2602_VRAM_ARB_STATS_EN
  input  logic              STAT_CLR,
  output logic [15:0]       STAT_CPU,
  output logic [15:0]       STAT_WAIT,
`endif
  input  logic              SLOT_STB,
  input  logic              SLOT_RENDER,
  input  logic [ADDR_W-1:0] REN_ADDR,
  output logic [7:0]        REN_DATA,
  output logic              REN_VALID,
  input  logic              CPU_WR_REQ,
  input  logic              CPU_RD_REQ,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic              CPU_BUSY,
  output logic [7:0]        CPU_RDATA,
  output logic              CPU_RD_VALID,
  output logic              SLOT_OVR,
  output logic [ADDR_W-2:0] VRAM_A,
  output logic [7:0]        VRAM_DO,
  input  logic [7:0]        VRAM_DI,
  output logic              VRAM_DOE,
  output logic              CE,
  output logic              OE,
  output logic              WE0,
  output logic              WE1
);

  logic              r_busy, r_pend, r_pend_wr, r_ovr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata, r_vram_do, r_ren_data, r_cpu_rdata;
  logic [ADDR_W-2:0] r_vram_a;

  logic       w_idle, w_grant_ren, w_grant_cpu, w_start, w_accept, w_odd;
  logic       w_capture, w_done, w_cpu_done;
  acc_e       w_acc;
  logic [1:0] w_gen_acc;

  assign w_accept    = !r_busy && (CPU_WR_REQ || CPU_RD_REQ);
  assign w_grant_ren = SLOT_STB && w_idle && SLOT_RENDER;
  assign w_grant_cpu = SLOT_STB && w_idle && !SLOT_RENDER && r_pend;
  assign w_start     = w_grant_ren || w_grant_cpu;
  assign w_cpu_done  = w_done && ((w_gen_acc == ACC_CPU_RD) || (w_gen_acc == ACC_CPU_WR));

  always_comb begin
    w_acc = ACC_NONE;
    w_odd = 1'b0;
    if (w_grant_ren) begin
      w_acc = ACC_REN;
      w_odd = REN_ADDR[0];
    end else if (w_grant_cpu) begin
      w_acc = r_pend_wr ? ACC_CPU_WR : ACC_CPU_RD;
      w_odd = r_addr[0];
    end
  end

  ym2602_vram_strobe_gen #(
    .STROBE_LEN(STROBE_LEN)
  ) u_strobe_gen (
    .i_clk    (MCLK),
    .i_rst    (RESET),
    .i_start  (w_start),
    .i_acc    (w_acc),
    .i_odd    (w_odd),
    .o_idle   (w_idle),
    .o_acc    (w_gen_acc),
    .o_ce     (CE),
    .o_oe     (OE),
    .o_we0    (WE0),
    .o_we1    (WE1),
    .o_doe    (VRAM_DOE),
    .o_capture(w_capture),
    .o_done   (w_done)
  );

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_wr   <= 1'b0;
      r_ovr       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_vram_a    <= '0;
      r_vram_do   <= '0;
      r_ren_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      // Accept needs !r_busy while grant/done need r_busy, so these never collide.
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_pend    <= 1'b1;
        r_pend_wr <= CPU_WR_REQ;
        r_addr    <= CPU_ADDR;
        r_wdata   <= CPU_WDATA;
      end
      if (w_grant_cpu) r_pend <= 1'b0;
      if (w_cpu_done) r_busy <= 1'b0;
      if (w_grant_ren) begin
        r_vram_a <= REN_ADDR[ADDR_W-1:1];
      end else if (w_grant_cpu) begin
        r_vram_a <= r_addr[ADDR_W-1:1];
        if (r_pend_wr) r_vram_do <= r_wdata;
      end
      if (w_capture && (w_gen_acc == ACC_REN)) r_ren_data <= VRAM_DI;
      if (w_capture && (w_gen_acc == ACC_CPU_RD)) r_cpu_rdata <= VRAM_DI;
      if (SLOT_STB && !w_idle) r_ovr <= 1'b1;
    end
  end

`ifdef YM2602_VRAM_ARB_STATS_EN
  logic [15:0] r_stat_cpu, r_stat_wait;

  always_ff @(posedge MCLK) begin
    if (RESET || STAT_CLR) begin
      r_stat_cpu  <= '0;
      r_stat_wait <= '0;
    end else begin
      if (w_cpu_done && (r_stat_cpu != 16'hFFFF)) r_stat_cpu <= r_stat_cpu + 16'd1;
      if (w_grant_ren && r_busy && (r_stat_wait != 16'hFFFF)) r_stat_wait <= r_stat_wait + 16'd1;
    end
  end

  assign STAT_CPU  = r_stat_cpu;
  assign STAT_WAIT = r_stat_wait;
`endif

  assign CPU_BUSY     = r_busy;
  assign SLOT_OVR     = r_ovr;
  assign VRAM_A       = r_vram_a;
  assign VRAM_DO      = r_vram_do;
  assign REN_DATA     = r_ren_data;
  assign CPU_RDATA    = r_cpu_rdata;
  assign REN_VALID    = w_done && (w_gen_acc == ACC_REN);
  assign CPU_RD_VALID = w_done && (w_gen_acc == ACC_CPU_RD);

endmodule

// File: tb/tb_ym2602_vram_arb.sv
// Scoreboard bench for ym2602_vram_arb: directed slot scenarios followed by random traffic.
module tb_ym2602_vram_arb;

  localparam int L = 2;

  logic        MCLK = 1'b0;
  logic        RESET, SLOT_STB, SLOT_RENDER, CPU_WR_REQ, CPU_RD_REQ;
  logic [13:0] REN_ADDR, CPU_ADDR;
  logic [7:0]  CPU_WDATA, REN_DATA, CPU_RDATA, VRAM_DO, VRAM_DI;
  logic        REN_VALID, CPU_BUSY, CPU_RD_VALID, SLOT_OVR, VRAM_DOE, CE, OE, WE0, WE1;
  logic [12:0] VRAM_A;
`ifdef YM2602_VRAM_ARB_STATS_EN
  logic        STAT_CLR = 1'b0;
  logic [15:0] STAT_CPU, STAT_WAIT;
  int          m_stat_cpu, m_stat_wait;
`endif

  ym2602_vram_arb #(.STROBE_LEN(L), .ADDR_W(14)) dut (
    .MCLK(MCLK), .RESET(RESET),
`ifdef YM2602_VRAM_ARB_STATS_EN
    .STAT_CLR(STAT_CLR), .STAT_CPU(STAT_CPU), .STAT_WAIT(STAT_WAIT),
`endif
    .SLOT_STB(SLOT_STB), .SLOT_RENDER(SLOT_RENDER), .REN_ADDR(REN_ADDR),
    .REN_DATA(REN_DATA), .REN_VALID(REN_VALID), .CPU_WR_REQ(CPU_WR_REQ),
    .CPU_RD_REQ(CPU_RD_REQ), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(CPU_BUSY), .CPU_RDATA(CPU_RDATA), .CPU_RD_VALID(CPU_RD_VALID),
    .SLOT_OVR(SLOT_OVR), .VRAM_A(VRAM_A), .VRAM_DO(VRAM_DO), .VRAM_DI(VRAM_DI),
    .VRAM_DOE(VRAM_DOE), .CE(CE), .OE(OE), .WE0(WE0), .WE1(WE1)
  );

  always #5 MCLK = ~MCLK;

  // Read-only VRAM contents; writes are checked on the bus, not stored.
  logic [7:0] rom [0:8191];
  assign VRAM_DI = rom[VRAM_A];

  typedef struct packed {logic [13:0] a; logic [7:0] d;} wr_t;
  logic [7:0] q_ren[$];
  logic [7:0] q_rd[$];
  wr_t        q_wr[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one CPU request slot, FSM busy window of L+3 cycles per access.
  int          cyc = 0;
  bit          m_pend, m_pend_wr, m_ovr;
  logic [13:0] m_addr;
  logic [7:0]  m_data;
  int          m_busy_until = 0;
  int          m_idle_at = 0;

  function automatic bit m_busy();
    return m_pend || (cyc < m_busy_until);
  endfunction

  task automatic tick();
    bit b;
    check("cpu_busy", CPU_BUSY, m_busy());
    check("slot_ovr", SLOT_OVR, m_ovr);
`ifdef YM2602_VRAM_ARB_STATS_EN
    check("stat_cpu", STAT_CPU, m_stat_cpu);
    check("stat_wait", STAT_WAIT, m_stat_wait);
`endif
    if (RESET) begin
      m_pend = 0; m_ovr = 0; m_busy_until = 0; m_idle_at = 0;
      q_ren.delete(); q_rd.delete(); q_wr.delete();
`ifdef YM2602_VRAM_ARB_STATS_EN
      m_stat_cpu = 0; m_stat_wait = 0;
`endif
    end else begin
      b = m_busy();
`ifdef YM2602_VRAM_ARB_STATS_EN
      if (cyc == m_busy_until - 1) m_stat_cpu++;
`endif
      if (SLOT_STB) begin
        if (cyc < m_idle_at) m_ovr = 1;
        else if (SLOT_RENDER) begin
          q_ren.push_back(rom[REN_ADDR[13:1]]);
          m_idle_at = cyc + L + 3;
`ifdef YM2602_VRAM_ARB_STATS_EN
          if (b) m_stat_wait++;
`endif
        end else if (m_pend) begin
          if (m_pend_wr) q_wr.push_back({m_addr, m_data});
          else q_rd.push_back(rom[m_addr[13:1]]);
          m_pend = 0;
          m_busy_until = cyc + L + 3;
          m_idle_at = cyc + L + 3;
        end
      end
      if (!b && (CPU_WR_REQ || CPU_RD_REQ)) begin
        m_pend = 1; m_pend_wr = CPU_WR_REQ; m_addr = CPU_ADDR; m_data = CPU_WDATA;
      end
    end
    @(posedge MCLK); #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    SLOT_STB = 0; SLOT_RENDER = 0; CPU_WR_REQ = 0; CPU_RD_REQ = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or starts a write strobe.
  logic prev_we = 1'b0;
  logic we_now;
  logic [7:0] exp_b;
  wr_t  exp_w;
  always @(negedge MCLK) begin
    if (REN_VALID === 1'b1) begin
      if (q_ren.size() == 0) check("ren_unexpected", 1, 0);
      else begin exp_b = q_ren.pop_front(); check("ren_data", REN_DATA, exp_b); end
    end
    if (CPU_RD_VALID === 1'b1) begin
      if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin exp_b = q_rd.pop_front(); check("cpu_rdata", CPU_RDATA, exp_b); end
    end
    if (OE === 1'b0) begin
      check("oe_we_excl", {WE1, WE0}, 2'b11);
      check("doe_on_read", VRAM_DOE, 0);
    end
    we_now = (WE0 === 1'b0) || (WE1 === 1'b0);
    if (we_now && !prev_we) begin
      if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        exp_w = q_wr.pop_front();
        check("wr_addr", VRAM_A, exp_w.a[13:1]);
        check("wr_sel", {WE1, WE0}, exp_w.a[0] ? 2'b01 : 2'b10);
        check("wr_data", VRAM_DO, exp_w.d);
        check("wr_doe", VRAM_DOE, 1);
      end
    end
    prev_we = we_now;
  end

  int next_slot;
  int r;

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
    rom[13'h091A] = 8'hA5;
    idle_inputs();
    REN_ADDR = '0; CPU_ADDR = '0; CPU_WDATA = '0;
    RESET = 1;
    @(posedge MCLK); @(posedge MCLK); #1;
    check("rst_strobes", {CE, OE, WE0, WE1}, 4'hF);
    check("rst_doe", VRAM_DOE, 0);
    check("rst_vram_a", VRAM_A, 0);
    check("rst_vram_do", VRAM_DO, 0);
    check("rst_valids", {REN_VALID, CPU_RD_VALID}, 0);
    check("rst_data", {REN_DATA, CPU_RDATA}, 0);
    check("rst_busy_ovr", {CPU_BUSY, SLOT_OVR}, 0);
    RESET = 0;
    tick();

    // Render read
    SLOT_STB = 1; SLOT_RENDER = 1; REN_ADDR = 14'h1235; tick(); idle_inputs();
    check("ren_setup_a", VRAM_A, 13'h091A);
    check("ren_setup_ce", {CE, OE}, 2'b01);
    tick(); check("ren_oe_t2", OE, 0);
    tick(); check("ren_oe_t3", OE, 0);
    tick(); check("ren_hold", {OE, REN_VALID, REN_DATA}, {2'b11, 8'hA5});
    tick(); check("ren_idle_ce", CE, 1);

    // CPU write, odd byte
    CPU_WR_REQ = 1; CPU_ADDR = 14'h0003; CPU_WDATA = 8'h5C; tick(); idle_inputs();
    SLOT_STB = 1; tick(); idle_inputs();
    check("wr_setup", {CE, VRAM_DOE, VRAM_DO, WE0, WE1}, {2'b01, 8'h5C, 2'b11});
    check("wr_setup_a", VRAM_A, 13'h0001);
    tick(); check("wr_t2", {WE0, WE1, VRAM_DOE}, 3'b101);
    tick(); check("wr_t3", {WE0, WE1, VRAM_DOE}, 3'b101);
    tick(); check("wr_hold", {CE, WE0, WE1, VRAM_DOE}, 4'b0111);
    tick(); check("wr_idle", {CE, VRAM_DOE}, 2'b10);

    // Priority: render slot starves the pending write; read request while busy is ignored
    CPU_WR_REQ = 1; CPU_ADDR = 14'h0A40; CPU_WDATA = 8'h3E; tick(); idle_inputs();
    CPU_RD_REQ = 1; CPU_ADDR = 14'h0100; tick(); idle_inputs();
    SLOT_STB = 1; SLOT_RENDER = 1; REN_ADDR = 14'h2222; tick(); idle_inputs();
    repeat (L + 2) tick();
    SLOT_STB = 1; tick(); idle_inputs();
    repeat (L + 3) tick();

    // Simultaneous WR+RD: only the write happens; a later free slot does nothing
    CPU_WR_REQ = 1; CPU_RD_REQ = 1; CPU_ADDR = 14'h1F00; CPU_WDATA = 8'hC3; tick(); idle_inputs();
    SLOT_STB = 1; tick(); idle_inputs();
    repeat (L + 3) tick();
    SLOT_STB = 1; tick(); idle_inputs();
    check("empty_slot_ce", CE, 1);
    repeat (L + 3) tick();

    // Overrun
    SLOT_STB = 1; SLOT_RENDER = 1; REN_ADDR = 14'h0777; tick(); idle_inputs();
    tick(); tick();
    SLOT_STB = 1; SLOT_RENDER = 1; REN_ADDR = 14'h0555; tick(); idle_inputs();
    check("ovr_set", SLOT_OVR, 1);
    repeat (L + 4) tick();
    check("ovr_sticky", SLOT_OVR, 1);

    // Reset during STROBE of a CPU read
    CPU_RD_REQ = 1; CPU_ADDR = 14'h0246; tick(); idle_inputs();
    SLOT_STB = 1; tick(); idle_inputs();
    tick();
    check("rd_strobe_oe", OE, 0);
    RESET = 1; tick(); RESET = 0;
    check("rst_mid_strobes", {CE, OE, WE0, WE1}, 4'hF);
    repeat (L + 4) tick();

    // Random traffic
    next_slot = cyc;
    for (int i = 0; i < 800; i++) begin
      SLOT_STB = (cyc >= next_slot);
      SLOT_RENDER = 1'($urandom);
      REN_ADDR = 14'($urandom);
      if (SLOT_STB) next_slot = cyc + L + 3 + int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      CPU_WR_REQ = (r < 2);
      CPU_RD_REQ = (r == 0) || (r == 2) || (r == 3);
      CPU_ADDR = 14'($urandom);
      CPU_WDATA = 8'($urandom);
      tick();
    end
    idle_inputs();
    repeat (L + 6) tick();
    check("q_ren_empty", q_ren.size(), 0);
    check("q_rd_empty", q_rd.size(), 0);
    check("q_wr_empty", q_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
